// File: rtl/acc_vec_engine_pkg.sv
// Shared types and sizes for the accelerator vector engine.
package acc_pkg;

    localparam int ACC_WORDS = 256;
    localparam int ACC_LANES = 4;

    typedef logic [ACC_LANES-1:0][7:0] acc_word_t;

    typedef enum logic [1:0] {
        ACC_ADD = 2'd0,
        ACC_SUB = 2'd1,
        ACC_MAX = 2'd2,
        ACC_XOR = 2'd3
    } acc_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } acc_state_e;

endpackage

// File: rtl/acc_vec_engine_if.sv
// Side-band bundle between the data RAM / core and the vector engine.
// The engine is the slave; the RAM side (or a bench) is the master.
interface acc_vec_engine_if
    import acc_pkg::*;
#(
    parameter int NUM_WORDS = ACC_WORDS
);
    logic      start_i;
    acc_op_e   op_i;
    acc_word_t acc_a_i   [NUM_WORDS-1:0];
    acc_word_t acc_b_i   [NUM_WORDS-1:0];
    acc_word_t acc_res_o [NUM_WORDS-1:0];
    logic      busy_o;
    logic      done_o;
    logic      err_o;

    modport master (
        output start_i, op_i, acc_a_i, acc_b_i,
        input  acc_res_o, busy_o, done_o, err_o
    );

    modport slave (
        input  start_i, op_i, acc_a_i, acc_b_i,
        output acc_res_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/acc_vec_engine_lane_alu.sv
// One byte lane of the vector datapath; purely combinational.
module acc_lane_alu
    import acc_pkg::*;
#(
    parameter bit SATURATE = 1'b0
) (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  acc_op_e    op_i,
    output logic [7:0] res_o
);
    logic [8:0] sum_w;
    logic [8:0] diff_w;

    // Ninth bit is the carry (add) or borrow (sub) used for clamping.
    assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_w = {1'b0, a_i} - {1'b0, b_i};

    // Select the lane result for the latched operation.
    always_comb begin
        res_o = '0;
        case (op_i)
            ACC_ADD: res_o = (SATURATE && sum_w[8])  ? 8'hFF : sum_w[7:0];
            ACC_SUB: res_o = (SATURATE && diff_w[8]) ? 8'h00 : diff_w[7:0];
            ACC_MAX: res_o = (a_i > b_i) ? a_i : b_i;
            ACC_XOR: res_o = a_i ^ b_i;
            default: res_o = '0;
        endcase
    end
endmodule

// File: rtl/acc_vec_engine.sv
// Vector engine: walks windows A and B one word per cycle through a
// two-stage pipeline and writes byte-lane results into the result window.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start_i; results hold the previous job
//   RUN   | issuing one word per cycle into stage 1
//   DRAIN | stage 2 retires the last issued word
//   DONE  | done_o high for this single cycle
module acc_vec_engine
    import acc_pkg::*;
#(
    parameter int NUM_WORDS = ACC_WORDS,
    parameter bit SATURATE  = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    acc_vec_engine_if.slave bus
);
    localparam int               IDX_W    = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    acc_state_e       state_q;
    acc_op_e          op_q;
    logic [IDX_W-1:0] idx_cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             v1_q;
    logic [IDX_W-1:0] idx_q;
    acc_word_t        a_q;
    acc_word_t        b_q;
    acc_word_t        res_d;
    acc_word_t        res_q [NUM_WORDS-1:0];

    // Sequencer with registered busy/done/err; the counter stops at the last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= ACC_ADD;
            idx_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && bus.start_i) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        state_q   <= RUN;
                        op_q      <= bus.op_i;
                        idx_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        err_q     <= 1'b0;
                    end
                end
                RUN: begin
                    if (idx_cnt_q == LAST_IDX) begin
                        state_q <= DRAIN;
                    end else begin
                        idx_cnt_q <= idx_cnt_q + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stage 1: sample the operand pair for the word being issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            idx_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            v1_q <= (state_q == RUN);
            if (state_q == RUN) begin
                idx_q <= idx_cnt_q;
                a_q   <= bus.acc_a_i[idx_cnt_q];
                b_q   <= bus.acc_b_i[idx_cnt_q];
            end
        end
    end

    for (genvar l = 0; l < ACC_LANES; l++) begin : g_lane
        acc_lane_alu #(
            .SATURATE (SATURATE)
        ) u_alu (
            .a_i   (a_q[l]),
            .b_i   (b_q[l]),
            .op_i  (op_q),
            .res_o (res_d[l])
        );
    end

    // Stage 2: retire the stage-1 word into the result window.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                res_q[i] <= '0;
            end
        end else if (v1_q) begin
            res_q[idx_q] <= res_d;
        end
    end

    assign bus.acc_res_o = res_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.err_o     = err_q;
endmodule

// File: tb/tb_acc_vec_engine.sv
// Directed bench for acc_vec_engine: one wrapping and one saturating
// instance share the same stimulus.
module tb_acc_vec_engine;
    import acc_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      start;
    acc_op_e   op;
    acc_word_t a_win [ACC_WORDS-1:0];
    acc_word_t b_win [ACC_WORDS-1:0];

    always #5 clk = ~clk;

    acc_vec_engine_if #(.NUM_WORDS(ACC_WORDS)) if0 ();
    acc_vec_engine_if #(.NUM_WORDS(ACC_WORDS)) if1 ();

    assign if0.start_i = start;
    assign if0.op_i    = op;
    assign if0.acc_a_i = a_win;
    assign if0.acc_b_i = b_win;
    assign if1.start_i = start;
    assign if1.op_i    = op;
    assign if1.acc_a_i = a_win;
    assign if1.acc_b_i = b_win;

    acc_vec_engine #(.NUM_WORDS(ACC_WORDS), .SATURATE(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    acc_vec_engine #(.NUM_WORDS(ACC_WORDS), .SATURATE(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc_rel;
    int done_at;
    int done_cnt;
    int busy_last;
    bit probe_on = 1'b0;
    int first_seen [ACC_WORDS];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic sample();
        if (if0.done_o) begin
            done_cnt++;
            if (done_at < 0) done_at = cyc_rel;
        end
        if (if0.busy_o) busy_last = cyc_rel;
        if (probe_on) begin
            for (int k = 0; k < ACC_WORDS; k++) begin
                if (first_seen[k] < 0 && if0.acc_res_o[k] == 32'(k)) first_seen[k] = cyc_rel;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc_rel++;
        sample();
    endtask

    // Start is sampled at the edge ending cycle T; returns in cycle T+1.
    task automatic start_job(input acc_op_e op_v);
        start = 1'b1;
        op    = op_v;
        @(posedge clk);
        #1;
        start     = 1'b0;
        op        = acc_op_e'(op_v ^ 2'd1);
        cyc_rel   = 1;
        done_at   = -1;
        done_cnt  = 0;
        busy_last = 0;
        sample();
    endtask

    task automatic wait_done();
        while (done_at < 0 && cyc_rel < 400) step();
        chk("done_cycle", 32'(done_at), 32'd258);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        acc_word_t orv;
        int        probe_k [8];
        probe_k = '{0, 1, 2, 3, 100, 200, 254, 255};

        rst   = 1'b1;
        start = 1'b0;
        op    = ACC_ADD;
        cyc_rel = 0; done_at = -1; done_cnt = 0; busy_last = 0;
        for (int k = 0; k < ACC_WORDS; k++) begin
            a_win[k] = '0;
            b_win[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        // start coincident with rst must be dropped
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_busy", 32'(if0.busy_o), 32'd0);
        chk("rst_done", 32'(if0.done_o), 32'd0);
        chk("rst_err",  32'(if0.err_o),  32'd0);
        chk("rst_res0", if0.acc_res_o[0], 32'h0);
        chk("rst_res255", if0.acc_res_o[255], 32'h0);
        step();
        chk("rst_start_dropped", 32'(if0.busy_o), 32'd0);

        // ADD, wrap vs saturate on the last word
        for (int k = 0; k < ACC_WORDS; k++) begin
            a_win[k] = {4{8'(k)}};
            b_win[k] = 32'h01010101;
        end
        start_job(ACC_ADD);
        wait_done();
        chk("add_busy_last", 32'(busy_last), 32'd257);
        step();
        chk("add_done_width", 32'(done_cnt), 32'd1);
        for (int k = 0; k < ACC_WORDS; k++) chk("add_word", if0.acc_res_o[k], {4{8'(k + 1)}});
        chk("add_wrap255", if0.acc_res_o[255], 32'h00000000);
        chk("add_sat255", if1.acc_res_o[255], 32'hFFFFFFFF);
        chk("add_sat7", if1.acc_res_o[7], 32'h08080808);

        // SUB, wrap vs clamp at zero
        for (int k = 0; k < ACC_WORDS; k++) begin
            a_win[k] = 32'h10203040;
            b_win[k] = 32'h20102030;
        end
        start_job(ACC_SUB);
        wait_done();
        step();
        for (int k = 0; k < ACC_WORDS; k++) chk("sub_wrap", if0.acc_res_o[k], 32'hF0101010);
        for (int k = 0; k < ACC_WORDS; k++) chk("sub_sat", if1.acc_res_o[k], 32'h00101010);

        // MAX with a start while busy
        start_job(ACC_MAX);
        while (cyc_rel < 200 && cyc_rel < 400) step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_start_err", 32'(if0.err_o), 32'd1);
        chk("busy_start_busy", 32'(if0.busy_o), 32'd1);
        wait_done();
        chk("err_sticky", 32'(if0.err_o), 32'd1);
        for (int k = 0; k < ACC_WORDS; k++) chk("max_word", if0.acc_res_o[k], 32'h20203040);
        step();

        // XOR accepted at the earliest cycle; clears err
        for (int k = 0; k < ACC_WORDS; k++) begin
            a_win[k] = 32'hFFFF0000;
            b_win[k] = 32'h0F0F0F0F;
        end
        start_job(ACC_XOR);
        chk("err_cleared", 32'(if0.err_o), 32'd0);
        chk("xor_busy", 32'(if0.busy_o), 32'd1);
        wait_done();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("done_start_err", 32'(if0.err_o), 32'd1);
        chk("done_start_ignored", 32'(if0.busy_o), 32'd0);
        step();
        chk("done_start_idle", 32'(if0.busy_o), 32'd0);
        chk("xor_done_width", 32'(done_cnt), 32'd1);
        for (int k = 0; k < ACC_WORDS; k++) chk("xor_word", if0.acc_res_o[k], 32'hF0F00F0F);

        // Latency probe: word k first shows k at cycle T+k+3
        for (int k = 0; k < ACC_WORDS; k++) begin
            a_win[k]      = 32'(k);
            b_win[k]      = 32'h0;
            first_seen[k] = -1;
        end
        probe_on = 1'b1;
        start_job(ACC_ADD);
        wait_done();
        probe_on = 1'b0;
        chk("probe_busy_last", 32'(busy_last), 32'd257);
        foreach (probe_k[i]) chk("probe_first", 32'(first_seen[probe_k[i]]), 32'(probe_k[i] + 3));
        step();

        // Reset mid-job
        for (int k = 0; k < ACC_WORDS; k++) begin
            a_win[k] = {4{8'(k)}};
            b_win[k] = 32'h02020202;
        end
        start_job(ACC_ADD);
        while (cyc_rel < 100) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 32'(if0.busy_o), 32'd0);
        chk("abort_done", 32'(if0.done_o), 32'd0);
        orv = '0;
        for (int k = 0; k < ACC_WORDS; k++) orv |= if0.acc_res_o[k];
        chk("abort_res_zero", orv, 32'h0);
        repeat (200) step();
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_busy_last", 32'(busy_last), 32'd100);

        // Fresh full job after the abort
        start_job(ACC_ADD);
        wait_done();
        step();
        for (int k = 0; k < ACC_WORDS; k++) chk("fresh_word", if0.acc_res_o[k], {4{8'(k + 2)}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
